mole_round_engine: RTL and testbench
====================================

MOLE_ROUND_ENGINE -- requirements
Module: mole_round_engine

Interface
REQ-001 SHALL have parameter N_HOLES, default 5, number of mole holes/hammer keys (2..8).
REQ-002 SHALL have parameter ROUNDS, default 25, mole appearances per game (1..127).
REQ-003 SHALL have parameter UNIT_CYC, default 10_000_000, clk cycles per time unit (0.1 s at 100 MHz).
REQ-004 SHALL have parameter SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-005 SHALL have parameter SCORE_W, default 7, width of score and miss counters.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  single-cycle game start request.
REQ-009 level  input  3  difficulty 0 (slowest) to 7 (fastest).
REQ-010 hammer  input  N_HOLES  debounced key levels, bit i = hole i.
REQ-011 mole  output  N_HOLES  one-hot active mole, zero when no mole shown.
REQ-012 hit_flash  output  1  high during SHOW after a hit.
REQ-013 miss_flash  output  1  high during SHOW after a timeout.
REQ-014 score, misses  output  SCORE_W each  hit count and miss count.
REQ-015 round_idx  output  7  completed-round count.
REQ-016 busy  output  1  high from the accepted start until DONE is entered.
REQ-017 done  output  1  single-cycle pulse when the game ends.

Function
REQ-018 FSM states SHALL be IDLE, GAP, UP, SHOW, DONE; every phase lasts PH units, PH from latched level: 20,15,12,10,8,6,5,4.
REQ-019 start in IDLE or DONE SHALL latch level, clear score/misses/round_idx, and enter GAP next cycle; start while busy is ignored.
REQ-020 Unit counter SHALL wrap at UNIT_CYC-1 and restart at 0 on every state change; phase ends on the unit tick that reaches PH.
REQ-021 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle from reset.
REQ-022 On GAP->UP, hole = LFSR[7:0] mod N_HOLES; if equal to previous hole, hole = (hole+1) mod N_HOLES.
REQ-023 mole SHALL be one-hot of hole in UP, zero in every other state, registered (one-cycle lag after state entry).
REQ-024 Hammer SHALL be edge-detected per bit; only cycles with exactly one rising edge and all other bits low count as a strike.
REQ-025 Strike on the active hole in UP: score += 1 (saturating at all-ones), enter SHOW with hit_flash.
REQ-026 Strike on another hole in UP: misses += 1 (saturating); mole stays up, timer continues.
REQ-027 UP phase expiry without hit: misses += 1 (saturating), enter SHOW with miss_flash.
REQ-028 Strike and expiry on the same cycle SHALL resolve as a hit.
REQ-029 Strikes outside UP SHALL be ignored; keys held across UP entry do not strike.
REQ-030 SHOW expiry: round_idx += 1; if round_idx reaches ROUNDS enter DONE, else GAP.
REQ-031 Entering DONE SHALL pulse done for one cycle, drop busy; score, misses, round_idx held until next start.

Reset
REQ-032 rst SHALL force IDLE, LFSR=SEED, all outputs 0, edge-detect history 0, at any time including mid-game.
REQ-033 After rst release a new start SHALL be required; no state resumes.

Verification
REQ-034 UNIT_CYC=4, ROUNDS=3, level=7: start, never strike -> mole each UP 16 cycles, misses=3, score=0, done pulse once.
REQ-035 Strike correct hole 2 cycles into every UP -> score=3, hit_flash each SHOW, misses=0.
REQ-036 Wrong-hole strike then correct strike in one UP -> misses=1, score=1.
REQ-037 Two keys rising same cycle on active hole -> no score change.
REQ-038 Assert rst mid-UP -> all outputs 0 next edge; start after release begins a fresh game with score=0.
REQ-039 SCORE_W=2, ROUNDS=5, all hits -> score saturates at 3; consecutive holes never repeat.

Source files
------------

// File: rtl/mole_round_engine.sv
// mole_round_engine: round sequencer for a whack-a-mole game.
// Walks IDLE -> (GAP -> UP -> SHOW) x ROUNDS -> DONE. Each phase lasts a
// level-dependent number of time units. A free-running LFSR picks the hole
// and never repeats the previous one. Hammer keys are edge detected, and a
// strike is a single clean key press.
module mole_round_engine #(
  parameter int          N_HOLES  = 5,
  parameter int          ROUNDS   = 25,
  parameter int          UNIT_CYC = 10_000_000,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          SCORE_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         level,
  input  logic [N_HOLES-1:0] hammer,
  output logic [N_HOLES-1:0] mole,
  output logic               hit_flash,
  output logic               miss_flash,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [6:0]         round_idx,
  output logic               busy,
  output logic               done
);

  localparam int                 UNIT_W      = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int                 HOLE_W      = $clog2(N_HOLES);
  localparam logic [UNIT_W-1:0]  UNIT_LAST   = UNIT_W'(UNIT_CYC - 1);
  localparam logic [HOLE_W-1:0]  HOLE_LAST   = HOLE_W'(N_HOLES - 1);
  localparam logic [6:0]         ROUNDS_LAST = 7'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_SAT   = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_SHOW,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [UNIT_W-1:0]  unit_cnt;
  logic [4:0]         ph_cnt;
  logic [4:0]         ph_len;
  logic [2:0]         level_q;
  logic [15:0]        lfsr;
  logic [N_HOLES-1:0] hammer_q;
  logic [N_HOLES-1:0] rise;
  logic [N_HOLES-1:0] hole_mask;
  logic [HOLE_W-1:0]  hole;
  logic [HOLE_W-1:0]  hole_cand;
  logic [HOLE_W-1:0]  hole_nx;
  logic               was_hit;
  logic               unit_tick;
  logic               phase_end;
  logic               strike;
  logic               strike_on_mole;
  logic               start_ok;
  logic               score_inc;
  logic               miss_inc;
  logic               round_inc;
  logic               hole_load;

  // Phase length in time units for the latched difficulty level.
  always_comb begin
    ph_len = 5'd20;
    case (level_q)
      3'd0: ph_len = 5'd20;
      3'd1: ph_len = 5'd15;
      3'd2: ph_len = 5'd12;
      3'd3: ph_len = 5'd10;
      3'd4: ph_len = 5'd8;
      3'd5: ph_len = 5'd6;
      3'd6: ph_len = 5'd5;
      3'd7: ph_len = 5'd4;
      default: ph_len = 5'd20;
    endcase
  end

  // Timer events, strike qualification and the active-hole decode.
  always_comb begin
    unit_tick      = (unit_cnt == UNIT_LAST);
    phase_end      = unit_tick && (ph_cnt == (ph_len - 5'd1));
    rise           = hammer & ~hammer_q;
    // A strike is exactly one new key with no other key held down.
    strike         = (rise != '0) && ((rise & (rise - N_HOLES'(1))) == '0) && (hammer == rise);
    hole_mask      = N_HOLES'(1) << hole;
    strike_on_mole = strike && (rise == hole_mask);
    start_ok       = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // Next hole: LFSR low byte modulo the hole count, bumped if it repeats.
  always_comb begin
    hole_cand = HOLE_W'(lfsr[7:0] % 8'(N_HOLES));
    hole_nx   = hole_cand;
    if (hole_cand == hole) begin
      hole_nx = (hole_cand == HOLE_LAST) ? '0 : hole_cand + HOLE_W'(1);
    end
  end

  // Game state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic, per-round scoring strobes and state-derived outputs.
  always_comb begin
    state_nx   = state;
    score_inc  = 1'b0;
    miss_inc   = 1'b0;
    round_inc  = 1'b0;
    hole_load  = 1'b0;
    busy       = 1'b0;
    hit_flash  = 1'b0;
    miss_flash = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (phase_end) begin
          state_nx  = S_UP;
          hole_load = 1'b1;
        end
      end
      S_UP: begin
        busy = 1'b1;
        // A hit wins over a simultaneous timeout.
        if (strike_on_mole) begin
          score_inc = 1'b1;
          state_nx  = S_SHOW;
        end else begin
          if (strike || phase_end) miss_inc = 1'b1;
          if (phase_end) state_nx = S_SHOW;
        end
      end
      S_SHOW: begin
        busy       = 1'b1;
        hit_flash  = was_hit;
        miss_flash = ~was_hit;
        if (phase_end) begin
          round_inc = 1'b1;
          state_nx  = (round_idx >= ROUNDS_LAST) ? S_DONE : S_GAP;
        end
      end
      S_DONE: begin
        if (start) state_nx = S_GAP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Unit and phase counters; both restart whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_cnt <= '0;
      ph_cnt   <= '0;
    end else if ((state_nx != state) || (state == S_IDLE) || (state == S_DONE)) begin
      unit_cnt <= '0;
      ph_cnt   <= '0;
    end else if (unit_tick) begin
      unit_cnt <= '0;
      ph_cnt   <= ph_cnt + 5'd1;
    end else begin
      unit_cnt <= unit_cnt + UNIT_W'(1);
    end
  end

  // Level latch plus score, miss and round counters for the current game.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= '0;
      score     <= '0;
      misses    <= '0;
      round_idx <= '0;
    end else if (start_ok) begin
      level_q   <= level;
      score     <= '0;
      misses    <= '0;
      round_idx <= '0;
    end else begin
      if (score_inc && (score != SCORE_SAT)) score <= score + SCORE_W'(1);
      if (miss_inc && (misses != SCORE_SAT)) misses <= misses + SCORE_W'(1);
      if (round_inc) round_idx <= round_idx + 7'd1;
    end
  end

  // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Key history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hammer_q <= '0;
    end else begin
      hammer_q <= hammer;
    end
  end

  // Active hole, chosen on the GAP to UP transition and kept as "previous".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hole <= '0;
    end else if (hole_load) begin
      hole <= hole_nx;
    end
  end

  // Remember how the UP phase ended so SHOW can flash the right lamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      was_hit <= 1'b0;
    end else if ((state == S_UP) && (state_nx == S_SHOW)) begin
      was_hit <= score_inc;
    end
  end

  // Registered mole lamps (trail the state by one cycle) and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mole <= '0;
      done <= 1'b0;
    end else begin
      mole <= (state == S_UP) ? hole_mask : '0;
      done <= (state_nx == S_DONE) && (state != S_DONE);
    end
  end

endmodule

// File: tb/tb_mole_round_engine.sv
// Testbench for mole_round_engine: randomized games, scoreboard queues of
// expected per-round and per-game results, checked by an independent monitor.
`timescale 1ns/1ps
module tb_mole_round_engine;

  localparam int          N      = 5;
  localparam int          RND    = 5;
  localparam int          U      = 4;
  localparam int          SW     = 2;
  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam int          SAT    = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    level = 3'd0;
  logic [N-1:0]  hammer = '0;
  logic [N-1:0]  mole;
  logic          hit_flash;
  logic          miss_flash;
  logic [SW-1:0] score;
  logic [SW-1:0] misses;
  logic [6:0]    round_idx;
  logic          busy;
  logic          done;

  mole_round_engine #(
    .N_HOLES (N),
    .ROUNDS  (RND),
    .UNIT_CYC(U),
    .SEED    (SEED_V),
    .SCORE_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .level     (level),
    .hammer    (hammer),
    .mole      (mole),
    .hit_flash (hit_flash),
    .miss_flash(miss_flash),
    .score     (score),
    .misses    (misses),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    int score;
    int misses;
    int rnd;
    int dur;
  } rexp_t;

  typedef struct {
    int score;
    int misses;
  } gexp_t;

  rexp_t rq[$];
  gexp_t gq[$];

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  function automatic int ph_of(input int lv);
    case (lv)
      0: return 20;
      1: return 15;
      2: return 12;
      3: return 10;
      4: return 8;
      5: return 6;
      6: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing every clock.
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= SEED_V;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Monitor state
  logic [15:0]  h0 = '0, h1 = '0, h2 = '0;
  logic [N-1:0] prev_mole = '0;
  logic [N-1:0] last_shown = '0;
  int           last_hole = 0;
  bit           prev_flash = 1'b0;
  bit           done_chk = 1'b0;
  int           run = 0;
  int           pend_dur = 0;
  int           m_cand;
  rexp_t        m_e;
  gexp_t        m_g;

  // Monitor: pops expectations whenever the DUT shows a mole, a flash or done.
  always @(negedge clk) begin
    h2 = h1;
    h1 = h0;
    h0 = lfsr_m;
    if (rst) begin
      prev_mole  = '0;
      last_shown = '0;
      last_hole  = 0;
      prev_flash = 1'b0;
      done_chk   = 1'b0;
      run        = 0;
      pend_dur   = 0;
    end else begin
      if (done_chk) begin
        check("done_one_cycle", done, 0);
        done_chk = 1'b0;
      end
      if ((mole != '0) && (prev_mole == '0)) begin
        // The hole was picked from the LFSR value present two samples ago.
        m_cand = int'(h2[7:0]) % N;
        if (m_cand == last_hole) m_cand = (m_cand + 1) % N;
        check("mole_hole", 32'(mole), 32'(1) << m_cand);
        check("mole_no_repeat", 32'(mole != last_shown), 1);
        last_hole  = m_cand;
        last_shown = mole;
        run        = 1;
      end else if (mole != '0) begin
        run++;
      end
      if ((mole == '0) && (prev_mole != '0) && (pend_dur != 0)) begin
        check("mole_up_cycles", run, pend_dur);
        pend_dur = 0;
      end
      if ((hit_flash || miss_flash) && !prev_flash) begin
        if (rq.size() == 0) begin
          check("flash_expected", 0, 1);
        end else begin
          m_e = rq.pop_front();
          check("hit_flash", hit_flash, m_e.hit);
          check("miss_flash", miss_flash, !m_e.hit);
          check("score_in_show", 32'(score), m_e.score);
          check("misses_in_show", 32'(misses), m_e.misses);
          check("round_in_show", 32'(round_idx), m_e.rnd);
          pend_dur = m_e.dur;
        end
      end
      if (done) begin
        if (gq.size() == 0) begin
          check("done_expected", 0, 1);
        end else begin
          m_g = gq.pop_front();
          check("final_score", 32'(score), m_g.score);
          check("final_misses", 32'(misses), m_g.misses);
          check("final_rounds", 32'(round_idx), RND);
          check("busy_at_done", busy, 0);
        end
        done_cnt++;
        done_chk = 1'b1;
      end
      prev_mole  = mole;
      prev_flash = hit_flash || miss_flash;
    end
  end

  task automatic wait_mole(input bit want_high);
    int c;
    c = 0;
    while (((mole != '0) != want_high) && (c < 400)) begin
      @(negedge clk);
      c++;
    end
    if ((mole != '0) != want_high) begin
      n_cmp++;
      n_fail++;
      $display("FAIL mole_wait: mole=%0d still not in wanted state %0d", mole, want_high);
      finish_run();
    end
  endtask

  task automatic press(input logic [N-1:0] mask);
    hammer = mask;
    @(negedge clk);
    hammer = '0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int lv);
    start = 1'b1;
    level = 3'(lv);
    @(negedge clk);
    start = 1'b0;
    level = 3'($urandom_range(0, 7));
  endtask

  // One game. kind_fixed < 0 picks a random behaviour per round:
  // 0 idle, 1 hit, 2 wrong then hit, 3 two keys at once, 4 wrong only,
  // 5 hit on the expiry cycle, 6 hit one cycle late, 7 keys held across UP entry.
  task automatic run_game(input int lv, input int kind_fixed, input bit extra_start);
    int sc, ms, len, kind, idx, wr, d, c, d0;
    logic [N-1:0] mm;
    rexp_t e;
    gexp_t g;
    sc  = 0;
    ms  = 0;
    len = ph_of(lv) * U;
    d0  = done_cnt;
    pulse_start(lv);
    check("busy_after_start", busy, 1);
    for (int r = 0; r < RND; r++) begin
      kind = (kind_fixed < 0) ? int'($urandom_range(0, 7)) : kind_fixed;
      if (kind == 7) hammer = '1;
      wait_mole(1);
      mm  = mole;
      idx = 0;
      for (int i = 0; i < N; i++) if (mm[i]) idx = i;
      wr = (idx + 1 + int'($urandom_range(0, N - 2))) % N;
      e.hit = 1'b0;
      e.dur = 0;
      case (kind)
        1, 5: begin sc = sat(sc + 1); e.hit = 1'b1; end
        2:    begin ms = sat(ms + 1); sc = sat(sc + 1); e.hit = 1'b1; end
        4:    begin ms = sat(ms + 2); e.dur = len; end
        default: begin ms = sat(ms + 1); e.dur = len; end
      endcase
      e.score  = sc;
      e.misses = ms;
      e.rnd    = r;
      rq.push_back(e);
      case (kind)
        1: begin
          d = int'($urandom_range(0, 4));
          repeat (d) @(negedge clk);
          press(mm);
        end
        2: begin
          press(N'(1) << wr);
          press(mm);
        end
        3: press(mm | (N'(1) << wr));
        4: press(N'(1) << wr);
        5: begin
          repeat (len - 2) @(negedge clk);
          hammer = mm;
          @(negedge clk);
          hammer = '0;
        end
        6: begin
          repeat (len - 1) @(negedge clk);
          press(mm);
        end
        7: begin
          repeat (2) @(negedge clk);
          hammer = '0;
        end
        default: ;
      endcase
      wait_mole(0);
      if (extra_start && (r == 1)) pulse_start(int'($urandom_range(0, 7)));
    end
    g.score  = sc;
    g.misses = ms;
    gq.push_back(g);
    c = 0;
    while ((done_cnt == d0) && (c < 600)) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: no done pulse within %0d cycles", c);
      finish_run();
    end
  endtask

  initial begin
    #5_000_000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mole", 32'(mole), 0);
    check("reset_hit_flash", hit_flash, 0);
    check("reset_miss_flash", miss_flash, 0);
    check("reset_score", 32'(score), 0);
    check("reset_misses", 32'(misses), 0);
    check("reset_round", 32'(round_idx), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_start_busy", busy, 0);

    run_game(7, 0, 1'b0);
    run_game(7, 1, 1'b0);
    run_game(int'($urandom_range(0, 7)), 2, 1'b0);
    run_game(int'($urandom_range(0, 7)), 3, 1'b0);
    run_game(int'($urandom_range(0, 7)), 4, 1'b1);
    run_game(int'($urandom_range(0, 7)), 5, 1'b0);
    run_game(int'($urandom_range(0, 7)), 6, 1'b0);
    run_game(int'($urandom_range(0, 7)), 7, 1'b0);

    // Reset in the middle of a game that already has a point on the board.
    begin
      rexp_t e;
      pulse_start(7);
      wait_mole(1);
      e.hit = 1'b1; e.score = 1; e.misses = 0; e.rnd = 0; e.dur = 0;
      rq.push_back(e);
      press(mole);
      wait_mole(0);
      wait_mole(1);
      rst = 1'b1;
      #1;
      check("midgame_rst_mole", 32'(mole), 0);
      check("midgame_rst_score", 32'(score), 0);
      check("midgame_rst_busy", busy, 0);
      check("midgame_rst_round", 32'(round_idx), 0);
      check("midgame_rst_flash", 32'({hit_flash, miss_flash, done}), 0);
      rq.delete();
      gq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_idle_mole", 32'(mole), 0);
    end

    for (int g = 0; g < 6; g++) begin
      run_game(int'($urandom_range(0, 7)), -1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("rounds_left_over", rq.size(), 0);
    check("games_left_over", gq.size(), 0);
    check("done_pulse_count", done_cnt, 14);
    finish_run();
  end

endmodule
